// File: rtl/byte_fifo_pkg.sv
// Shared types for the byte output FIFO: word FIFO entry layout and staging size.
package byte_fifo_pkg;

    typedef logic [2:0] bytecnt_t;

    typedef struct packed {
        logic [1:0]  len_m1;
        logic [31:0] data;
    } word_entry_t;

    localparam int STAGE_BYTES = 7;

endpackage

// File: rtl/byte_output_fifo_word_fifo.sv
// Single-clock word FIFO with one-cycle registered read data (two cycles with OUT_REG=1).
// USE_BLOCK selects a block-RAM style read register or a distributed-RAM style read path.
module SingleClockFifo #(
    parameter int  WIDTH     = 34,
    parameter int  DEPTH     = 512,
    parameter int  USE_BLOCK = 1,
    parameter int  OUT_REG   = 0,
    localparam int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic [WIDTH-1:0]     din,
    input  logic                 rd,
    output logic [WIDTH-1:0]     dout,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_BITS:0]   wsize
);
    localparam logic [ADDR_BITS:0]   FULL_CNT = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS-1:0] LAST_PTR = ADDR_BITS'(DEPTH - 1);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   count;
    logic                 wr_en;
    logic                 rd_en;
    logic [WIDTH-1:0]     rd_data;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign wsize = FULL_CNT - count;
    assign wr_en = wr && !full;
    assign rd_en = rd && !empty;

    function automatic logic [ADDR_BITS-1:0] ptr_inc(input logic [ADDR_BITS-1:0] p);
        return (p == LAST_PTR) ? '0 : p + ADDR_BITS'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (ADDR_BITS+1)'(1);
                2'b01:   count <= count - (ADDR_BITS+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    generate
        if (USE_BLOCK != 0) begin : g_block
            // Block RAM output register carries no reset; consumers qualify it.
            always_ff @(posedge clk) begin
                if (rd_en) rd_data <= mem[rd_ptr];
            end
        end else begin : g_dist
            logic [WIDTH-1:0] mem_rd;
            assign mem_rd = mem[rd_ptr];
            always_ff @(posedge clk) begin
                if (reset)      rd_data <= '0;
                else if (rd_en) rd_data <= mem_rd;
            end
        end

        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (reset) dout_q <= '0;
                else       dout_q <= rd_data;
            end
            assign dout = dout_q;
        end else begin : g_no_out_reg
            assign dout = rd_data;
        end
    endgenerate

endmodule

// File: rtl/byte_output_fifo.sv
// Byte-granular read-side FIFO: 32-bit words in, 1-4 big-endian bytes out per clock.
// Define BYTE_OUTPUT_FIFO_BYTECOUNT_EN to add a byte_count output of all buffered bytes.
module byte_output_fifo
    import byte_fifo_pkg::*;
#(
    parameter int  DEPTH     = 512,
    parameter int  USE_BLOCK = 1,
    localparam int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic [31:0]          din,
    input  logic [2:0]           wr_bytes,
    input  logic                 rd,
    input  logic [2:0]           rd_bytes,
    output logic [31:0]          dout,
    output logic [2:0]           rd_avail,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 empty,
    output logic                 full,
`ifdef BYTE_OUTPUT_FIFO_BYTECOUNT_EN
    output logic [ADDR_BITS+3:0] byte_count,
`endif
    output logic [ADDR_BITS:0]   wsize
);
    localparam int STAGE_W = STAGE_BYTES * 8;

    word_entry_t        wr_entry;
    word_entry_t        rd_entry;
    logic [1:0]         wr_len_m1;
    logic               fifo_wr;
    logic               fifo_rd;
    logic               fifo_empty;
    logic               fifo_full;

    logic [STAGE_W-1:0] stage_q;
    logic [STAGE_W-1:0] stage_d;
    logic [STAGE_W-1:0] stage_shift;
    logic [STAGE_W-1:0] land_bits;
    logic [31:0]        land_data;
    bytecnt_t           cnt_q;
    bytecnt_t           cnt_d;
    bytecnt_t           cnt_consumed;
    bytecnt_t           land_len;
    logic               in_flight_q;
    logic               rd_ok;
    logic               overflow_q;
    logic               underflow_q;

    // Out-of-range byte counts are treated as a full word.
    assign wr_len_m1 = (wr_bytes >= 3'd1 && wr_bytes <= 3'd4) ? 2'(wr_bytes - 3'd1) : 2'd3;
    assign wr_entry  = {wr_len_m1, din};
    assign fifo_wr   = wr && !fifo_full;

    SingleClockFifo #(
        .WIDTH     ($bits(word_entry_t)),
        .DEPTH     (DEPTH),
        .USE_BLOCK (USE_BLOCK),
        .OUT_REG   (0)
    ) u_word_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (fifo_wr),
        .din   (wr_entry),
        .rd    (fifo_rd),
        .dout  (rd_entry),
        .empty (fifo_empty),
        .full  (fifo_full),
        .wsize (wsize)
    );

    assign rd_avail = (cnt_q > 3'd4) ? 3'd4 : cnt_q;
    assign rd_ok    = rd && (rd_bytes != 3'd0) && (rd_bytes <= 3'd4) && (rd_bytes <= rd_avail);

    always_comb begin
        stage_shift  = stage_q;
        cnt_consumed = cnt_q;
        if (rd_ok) begin
            stage_shift  = stage_q << {rd_bytes, 3'b000};
            cnt_consumed = cnt_q - rd_bytes;
        end

        land_data = '0;
        land_len  = '0;
        land_bits = '0;
        if (in_flight_q) begin
            // Unused lanes of a short word are dropped so the stage tail stays zero.
            for (int i = 0; i < 4; i++) begin
                if (i <= int'(rd_entry.len_m1))
                    land_data[31-8*i -: 8] = rd_entry.data[31-8*i -: 8];
            end
            land_len  = {1'b0, rd_entry.len_m1} + 3'd1;
            land_bits = {land_data, {(STAGE_W-32){1'b0}}} >> {cnt_consumed, 3'b000};
        end

        stage_d = stage_shift | land_bits;
        cnt_d   = cnt_consumed + land_len;
    end

    // Landing data counts in cnt_d, so a new pop may issue the same cycle one lands
    // while the next landing still fits in the seven-byte stage.
    assign fifo_rd = !fifo_empty && (cnt_d <= 3'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q     <= '0;
            cnt_q       <= '0;
            in_flight_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            stage_q     <= stage_d;
            cnt_q       <= cnt_d;
            in_flight_q <= fifo_rd;
            overflow_q  <= wr && fifo_full;
            underflow_q <= rd && !rd_ok;
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(rd_avail))
                dout[31-8*i -: 8] = stage_q[STAGE_W-1-8*i -: 8];
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign full      = fifo_full;
    assign empty     = fifo_empty && !in_flight_q && (cnt_q == '0);

`ifdef BYTE_OUTPUT_FIFO_BYTECOUNT_EN
    logic [ADDR_BITS+3:0] byte_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_count_q <= '0;
        end else begin
            byte_count_q <= byte_count_q
                          + (fifo_wr ? (ADDR_BITS+4)'({1'b0, wr_len_m1} + 3'd1) : '0)
                          - (rd_ok   ? (ADDR_BITS+4)'(rd_bytes) : '0);
        end
    end

    assign byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_byte_output_fifo.sv
// Directed self-checking bench for byte_output_fifo (DEPTH=16), with hand-computed expectations.
module tb_byte_output_fifo;
    localparam int DEPTH     = 16;
    localparam int ADDR_BITS = 4;

    logic                 clk;
    logic                 reset;
    logic                 wr;
    logic [31:0]          din;
    logic [2:0]           wr_bytes;
    logic                 rd;
    logic [2:0]           rd_bytes;
    logic [31:0]          dout;
    logic [2:0]           rd_avail;
    logic                 overflow;
    logic                 underflow;
    logic                 empty;
    logic                 full;
    logic [ADDR_BITS:0]   wsize;
`ifdef BYTE_OUTPUT_FIFO_BYTECOUNT_EN
    logic [ADDR_BITS+3:0] byte_count;
`endif

    int checks   = 0;
    int failures = 0;

    byte_output_fifo #(.DEPTH(DEPTH), .USE_BLOCK(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr),
        .din        (din),
        .wr_bytes   (wr_bytes),
        .rd         (rd),
        .rd_bytes   (rd_bytes),
        .dout       (dout),
        .rd_avail   (rd_avail),
        .overflow   (overflow),
        .underflow  (underflow),
        .empty      (empty),
        .full       (full),
`ifdef BYTE_OUTPUT_FIFO_BYTECOUNT_EN
        .byte_count (byte_count),
`endif
        .wsize      (wsize)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr    = 1'b0;
        rd    = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wr_word(input logic [31:0] d, input logic [2:0] n);
        wr       = 1'b1;
        din      = d;
        wr_bytes = n;
        tick();
        wr = 1'b0;
    endtask

    task automatic rd_op(input logic [2:0] n);
        rd       = 1'b1;
        rd_bytes = n;
        tick();
        rd = 1'b0;
    endtask

    // Timeout is caught by the rd_avail check that always follows.
    task automatic wait_avail(input logic [2:0] n);
        for (int k = 0; k < 20; k++) begin
            if (rd_avail >= n) break;
            tick();
        end
    endtask

    function automatic logic [31:0] word_of(input int k);
        return {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
    endfunction

    initial begin
        int nw;
        int nr;
        logic seen_uf;

        wr = 0; din = '0; wr_bytes = 3'd4; rd = 0; rd_bytes = 3'd1; reset = 1'b1;
        tick();
        do_reset();
        check_val("rst_avail", 64'(rd_avail), 0);
        check_val("rst_dout", 64'(dout), 0);
        check_val("rst_ovf", 64'(overflow), 0);
        check_val("rst_udf", 64'(underflow), 0);
        check_val("rst_empty", 64'(empty), 1);
        check_val("rst_full", 64'(full), 0);
        check_val("rst_wsize", 64'(wsize), DEPTH);

        // unaligned reads across a word boundary
        wr_word(32'h11223344, 3'd4);
        wr_word(32'h55667788, 3'd4);
        wait_avail(3'd4);
        check_val("ua_avail1", 64'(rd_avail), 4);
        check_val("ua_dout1", 64'(dout), 64'h11223344);
        rd_op(3'd3);
        check_val("ua_udf", 64'(underflow), 0);
        wait_avail(3'd4);
        check_val("ua_avail2", 64'(rd_avail), 4);
        check_val("ua_dout2", 64'(dout), 64'h44556677);
        rd_op(3'd3);
        check_val("ua_avail3", 64'(rd_avail), 2);
        check_val("ua_dout3", 64'(dout), 64'h77880000);
        rd_op(3'd2);
        check_val("ua_empty", 64'(empty), 1);

        // short final word and over-read
        wr_word(32'hAABBCC00, 3'd3);
        wait_avail(3'd3);
        check_val("sh_avail", 64'(rd_avail), 3);
        check_val("sh_dout", 64'(dout), 64'hAABBCC00);
        rd_op(3'd4);
        check_val("sh_udf_pulse", 64'(underflow), 1);
        check_val("sh_avail_kept", 64'(rd_avail), 3);
        tick();
        check_val("sh_udf_clear", 64'(underflow), 0);
        rd_op(3'd3);
        check_val("sh_udf_legal", 64'(underflow), 0);
        check_val("sh_empty", 64'(empty), 1);

        // lane masking, rd_bytes=0 illegal, wr_bytes=0 means 4
        wr_word(32'h12345678, 3'd2);
        wait_avail(3'd2);
        check_val("mask_avail", 64'(rd_avail), 2);
        check_val("mask_dout", 64'(dout), 64'h12340000);
        rd_op(3'd0);
        check_val("rd0_udf", 64'(underflow), 1);
        check_val("rd0_avail", 64'(rd_avail), 2);
        rd_op(3'd2);
        wr_word(32'h01020304, 3'd0);
        wait_avail(3'd4);
        check_val("wb0_avail", 64'(rd_avail), 4);
        check_val("wb0_dout", 64'(dout), 64'h01020304);
        rd_op(3'd4);
        check_val("wb0_empty", 64'(empty), 1);

        // streaming 64 words through the 16-deep FIFO
        nw = 0;
        nr = 0;
        seen_uf = 1'b0;
        fork
            begin
                for (int cyc = 0; cyc < 2000 && nw < 64; cyc++) begin
                    if (!full) begin
                        wr = 1'b1; din = word_of(nw); wr_bytes = 3'd4; nw++;
                    end else begin
                        wr = 1'b0;
                    end
                    tick();
                end
                wr = 1'b0;
            end
            begin
                for (int cyc = 0; cyc < 3000 && nr < 64; cyc++) begin
                    if (underflow) seen_uf = 1'b1;
                    if (rd_avail == 3'd4) begin
                        check_val("stream_data", 64'(dout), 64'(word_of(nr)));
                        rd = 1'b1; rd_bytes = 3'd4; nr++;
                    end else begin
                        rd = 1'b0;
                    end
                    tick();
                end
                rd = 1'b0;
            end
        join
        tick();
        check_val("stream_words", 64'(nr), 64);
        check_val("stream_udf", 64'(seen_uf), 0);
        check_val("stream_empty", 64'(empty), 1);

        // overflow: one word always sits in the stage, so 17 writes fill the 16-deep FIFO
        for (int i = 0; i < 17; i++) wr_word(32'hA0000000 + 32'(i), 3'd4);
        check_val("ovf_full", 64'(full), 1);
        check_val("ovf_wsize", 64'(wsize), 0);
        check_val("ovf_pre", 64'(overflow), 0);
        wr_word(32'hFFFFFFFF, 3'd4);
        check_val("ovf_pulse", 64'(overflow), 1);
        tick();
        check_val("ovf_clear", 64'(overflow), 0);
        nr = 0;
        for (int cyc = 0; cyc < 400 && nr < 18; cyc++) begin
            if (rd_avail == 3'd4) begin
                check_val("ovf_data", 64'(dout), 64'(32'hA0000000 + 32'(nr)));
                rd = 1'b1; rd_bytes = 3'd4; nr++;
            end else begin
                rd = 1'b0;
            end
            tick();
        end
        rd = 1'b0;
        check_val("ovf_bytes", 64'(nr * 4), 68);
        check_val("ovf_empty", 64'(empty), 1);

        // reset while a pop is in flight and the stage is partly full
        wr_word(32'h01010101, 3'd4);
        wr_word(32'h02020202, 3'd4);
        wr_word(32'h03030303, 3'd4);
        wait_avail(3'd4);
        rd_op(3'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("mrst_avail", 64'(rd_avail), 0);
        check_val("mrst_empty", 64'(empty), 1);
        check_val("mrst_wsize", 64'(wsize), DEPTH);
        check_val("mrst_dout", 64'(dout), 0);
        wr_word(32'hDEADBEEF, 3'd4);
        check_val("lat_n1", 64'(rd_avail), 0);
        tick();
        check_val("lat_n2", 64'(rd_avail), 0);
        tick();
        check_val("lat_n3_avail", 64'(rd_avail), 4);
        check_val("lat_n3_dout", 64'(dout), 64'hDEADBEEF);
        rd_op(3'd4);
        check_val("lat_empty", 64'(empty), 1);

`ifdef BYTE_OUTPUT_FIFO_BYTECOUNT_EN
        do_reset();
        check_val("bc_rst", 64'(byte_count), 0);
        wr_word(32'h11223344, 3'd4);
        check_val("bc_wr4", 64'(byte_count), 4);
        wr_word(32'h55660000, 3'd2);
        check_val("bc_wr2", 64'(byte_count), 6);
        wait_avail(3'd1);
        rd_op(3'd1);
        check_val("bc_rd1", 64'(byte_count), 5);
        do_reset();
        check_val("bc_rst2", 64'(byte_count), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
